// File: rtl/tl_sink_id_allocator_pkg.sv
// Shared types and helpers for the TileLink manager-side sink-ID allocator.
// The sink-ID width is fixed here so every file agrees on the bitmap width.
package tl_sink_id_allocator_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int SINK_BITS   = 2;
   localparam int NUM_SINKS   = 2 ** SINK_BITS;

   typedef logic [SINK_BITS-1:0] sink_id_t;
   typedef logic [NUM_SINKS-1:0] sink_map_t;

   // Walks from the top down so the lowest clear bit is the one that sticks.
   function automatic sink_id_t lowest_zero_idx(input sink_map_t map);
      sink_id_t idx;
      idx = '0;
      for (int i = NUM_SINKS - 1; i >= 0; i--) begin
         if (!map[i]) idx = sink_id_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/tl_sink_id_allocator_if.sv
// Request, grant and GrantAck signals of the sink-ID allocator, bundled.
// master = requesters/D-channel/E-queue side, slave = the allocator.
interface tl_sink_id_allocator_if
   import tl_sink_id_allocator_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int REQ_BITS = $clog2(NUM_REQ)
) ();

   logic [NUM_REQ-1:0]  io_req_valid;
   logic [NUM_REQ-1:0]  io_req_ready;
   logic                io_grant_valid;
   logic                io_grant_ready;
   logic [REQ_BITS-1:0] io_grant_req;
   sink_id_t            io_grant_sink;
   logic                io_ack_valid;
   sink_id_t            io_ack_sink;
   sink_map_t           io_busy;
   logic                io_idle;
   logic                io_err;

   modport master (
      output io_req_valid, io_grant_ready, io_ack_valid, io_ack_sink,
      input  io_req_ready, io_grant_valid, io_grant_req, io_grant_sink,
             io_busy, io_idle, io_err
   );

   modport slave (
      input  io_req_valid, io_grant_ready, io_ack_valid, io_ack_sink,
      output io_req_ready, io_grant_valid, io_grant_req, io_grant_sink,
             io_busy, io_idle, io_err
   );

endinterface

// File: rtl/tl_sink_id_allocator_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last winner and wraps.
// NUM_REQ need not be a power of two, so the wrap is an explicit subtract.
module tl_sink_id_allocator_rr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int REQ_BITS = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  i_valid,
   input  logic [REQ_BITS-1:0] i_ptr,
   output logic [REQ_BITS-1:0] o_win,
   output logic                o_any
);

   logic [REQ_BITS:0]   w_sum;
   logic [REQ_BITS-1:0] w_idx;
   logic                w_found;

   always_comb begin
      o_win   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_sum = {1'b0, i_ptr} + (REQ_BITS+1)'(k);
         if (w_sum >= (REQ_BITS+1)'(NUM_REQ)) w_sum = w_sum - (REQ_BITS+1)'(NUM_REQ);
         w_idx = w_sum[REQ_BITS-1:0];
         if (!w_found && i_valid[w_idx]) begin
            w_found = 1'b1;
            o_win   = w_idx;
         end
      end
   end

   assign o_any = |i_valid;

endmodule

// File: rtl/tl_sink_id_allocator.sv
// Sink-ID allocator: round-robin grant issue with a registered output slot,
// IDs returned to the pool by E-channel GrantAcks.
module tl_sink_id_allocator
   import tl_sink_id_allocator_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int REQ_BITS = $clog2(NUM_REQ)
) (
   input logic                    clock,
   input logic                    reset,
   tl_sink_id_allocator_if.slave  bus
);

   sink_map_t           r_busy;
   logic [REQ_BITS-1:0] r_rr_ptr;
   logic                r_out_valid;
   logic [REQ_BITS-1:0] r_out_req;
   sink_id_t            r_out_sink;
   logic                r_err;

   logic [REQ_BITS-1:0] w_win;
   logic                w_any_valid;
   logic                w_slot_free;
   logic                w_any_free;
   sink_id_t            w_free_id;
   logic [NUM_REQ-1:0]  w_req_ready;
   logic                w_fire;
   logic                w_ack_hit;
   sink_map_t           w_busy_next;

   tl_sink_id_allocator_rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .REQ_BITS (REQ_BITS)
   ) u_arb (
      .i_valid (bus.io_req_valid),
      .i_ptr   (r_rr_ptr),
      .o_win   (w_win),
      .o_any   (w_any_valid)
   );

   // Draining the slot this cycle lets a new grant load behind it without a bubble.
   assign w_slot_free = ~r_out_valid | bus.io_grant_ready;
   assign w_any_free  = ~&r_busy;
   assign w_free_id   = lowest_zero_idx(r_busy);

   always_comb begin
      w_req_ready = '0;
      if (w_slot_free && w_any_free && w_any_valid) w_req_ready[w_win] = 1'b1;
   end

   assign w_fire    = |(bus.io_req_valid & w_req_ready);
   assign w_ack_hit = bus.io_ack_valid & r_busy[bus.io_ack_sink];

   // Release clears a set bit and allocation sets a clear one, so they never collide.
   always_comb begin
      w_busy_next = r_busy;
      if (w_ack_hit) w_busy_next[bus.io_ack_sink] = 1'b0;
      if (w_fire)    w_busy_next[w_free_id]       = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_busy      <= '0;
         r_rr_ptr    <= REQ_BITS'(NUM_REQ - 1);
         r_out_valid <= 1'b0;
         r_out_req   <= '0;
         r_out_sink  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_busy <= w_busy_next;
         if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_req   <= w_win;
            r_out_sink  <= w_free_id;
            r_rr_ptr    <= w_win;
         end else if (bus.io_grant_ready && r_out_valid) begin
            r_out_valid <= 1'b0;
         end
         if (bus.io_ack_valid && !r_busy[bus.io_ack_sink]) r_err <= 1'b1;
      end
   end

   assign bus.io_req_ready   = w_req_ready;
   assign bus.io_grant_valid = r_out_valid;
   assign bus.io_grant_req   = r_out_req;
   assign bus.io_grant_sink  = r_out_sink;
   assign bus.io_busy        = r_busy;
   assign bus.io_idle        = ~|r_busy & ~r_out_valid;
   assign bus.io_err         = r_err;

endmodule

// File: tb/tb_tl_sink_id_allocator.sv
// Scenario bench for the sink-ID allocator: a behavioural model queues expected
// grants as stimulus is applied, and each scenario compares the DUT inline.
module tb_tl_sink_id_allocator;
   import tl_sink_id_allocator_pkg::*;

   localparam int NR = 4;

   typedef struct packed {
      logic [1:0] req;
      sink_id_t   sink;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   tl_sink_id_allocator_if #(.NUM_REQ(NR)) bus ();

   tl_sink_id_allocator #(.NUM_REQ(NR)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int        n_checks = 0;
   int        n_fail   = 0;
   logic [3:0] m_busy;
   int        m_ptr;
   bit        m_ov;
   bit        m_err;
   exp_t      q[$];

   function automatic int model_win(input logic [3:0] v);
      for (int k = 1; k <= NR; k++) begin
         if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_ready();
      logic [3:0] r;
      int w;
      r = 4'b0;
      w = model_win(bus.io_req_valid);
      if (w >= 0 && (!m_ov || bus.io_grant_ready) && m_busy != 4'hF) r[w] = 1'b1;
      return r;
   endfunction

   function automatic int model_free();
      for (int i = 0; i < 4; i++) if (!m_busy[i]) return i;
      return 0;
   endfunction

   task automatic drive(input logic [3:0] rv, input logic gr, input logic av, input sink_id_t a_sink);
      @(negedge clock);
      reset              = 1'b0;
      bus.io_req_valid   = rv;
      bus.io_grant_ready = gr;
      bus.io_ack_valid   = av;
      bus.io_ack_sink    = a_sink;
      #1;
   endtask

   // Advances the model across the coming edge, pushing any grant it expects.
   task automatic tick();
      logic [3:0] rdy;
      logic [3:0] nb;
      int w, f;
      rdy = model_ready();
      w   = model_win(bus.io_req_valid);
      nb  = m_busy;
      if (reset) begin
         m_busy = 4'b0; m_ptr = NR - 1; m_ov = 1'b0; m_err = 1'b0;
         q.delete();
      end else begin
         if (bus.io_ack_valid) begin
            if (m_busy[bus.io_ack_sink]) nb[bus.io_ack_sink] = 1'b0;
            else m_err = 1'b1;
         end
         if (m_ov && bus.io_grant_ready && q.size() > 0) void'(q.pop_front());
         if (rdy != 4'b0) begin
            f = model_free();
            nb[f] = 1'b1;
            q.push_back('{req: 2'(w), sink: sink_id_t'(f)});
            m_ptr = w;
            m_ov  = 1'b1;
         end else if (bus.io_grant_ready) begin
            m_ov = 1'b0;
         end
         m_busy = nb;
      end
      @(posedge clock);
   endtask

   task automatic do_reset();
      drive(4'b0, 1'b0, 1'b0, '0);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      drive(4'b0, 1'b0, 1'b0, '0);
      n_checks++; if (bus.io_grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_grant_valid: got %b expected 0", bus.io_grant_valid); end
      n_checks++; if (bus.io_req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", bus.io_req_ready); end
      n_checks++; if (bus.io_busy !== 4'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0000", bus.io_busy); end
      n_checks++; if (bus.io_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", bus.io_idle); end
      n_checks++; if (bus.io_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.io_err); end
      tick();
   endtask

   task automatic test_single();
      logic [3:0] exp_rdy;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive((i < 5) ? 4'b0001 : 4'b0000, 1'b1, 1'b0, '0);
         exp_rdy = (i < 4) ? 4'b0001 : 4'b0000;
         n_checks++; if (bus.io_req_ready !== exp_rdy) begin n_fail++; $display("FAIL single_ready[%0d]: got %b expected %b", i, bus.io_req_ready, exp_rdy); end
         if (i >= 1 && i <= 4) begin
            n_checks++;
            if (bus.io_grant_valid !== 1'b1 || bus.io_grant_req !== 2'd0 || bus.io_grant_sink !== sink_id_t'(i - 1)) begin
               n_fail++; $display("FAIL single_grant[%0d]: got v=%b req=%0d sink=%0d expected v=1 req=0 sink=%0d", i, bus.io_grant_valid, bus.io_grant_req, bus.io_grant_sink, i - 1);
            end
         end
         if (m_ov) begin
            n_checks++;
            if (bus.io_grant_req !== q[0].req || bus.io_grant_sink !== q[0].sink) begin
               n_fail++; $display("FAIL single_sb[%0d]: got req=%0d sink=%0d expected req=%0d sink=%0d", i, bus.io_grant_req, bus.io_grant_sink, q[0].req, q[0].sink);
            end
         end
         if (i == 5) begin
            n_checks++; if (bus.io_busy !== 4'b1111) begin n_fail++; $display("FAIL single_busy: got %b expected 1111", bus.io_busy); end
            n_checks++; if (bus.io_grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b expected 0", bus.io_grant_valid); end
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      logic     av;
      sink_id_t a_sink;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         av     = m_ov;
         a_sink = m_ov ? q[0].sink : '0;
         drive(4'b1111, 1'b1, av, a_sink);
         if (i >= 1) begin
            n_checks++;
            if (bus.io_grant_valid !== 1'b1 || bus.io_grant_req !== 2'((i - 1) % 4)) begin
               n_fail++; $display("FAIL rr_winner[%0d]: got v=%b req=%0d expected v=1 req=%0d", i, bus.io_grant_valid, bus.io_grant_req, (i - 1) % 4);
            end
            n_checks++;
            if (bus.io_grant_sink !== q[0].sink) begin
               n_fail++; $display("FAIL rr_sink[%0d]: got %0d expected %0d", i, bus.io_grant_sink, q[0].sink);
            end
         end
         n_checks++; if (bus.io_req_ready !== model_ready()) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, bus.io_req_ready, model_ready()); end
         n_checks++; if (bus.io_busy !== m_busy) begin n_fail++; $display("FAIL rr_busy[%0d]: got %b expected %b", i, bus.io_busy, m_busy); end
         tick();
      end
   endtask

   task automatic test_exhaust();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(4'b0001, 1'b1, 1'b0, '0);
         tick();
      end
      drive(4'b1111, 1'b1, 1'b0, '0);
      n_checks++; if (bus.io_req_ready !== 4'b0) begin n_fail++; $display("FAIL exh_full_ready: got %b expected 0000", bus.io_req_ready); end
      tick();
      drive(4'b1111, 1'b1, 1'b1, 2'd2);
      n_checks++; if (bus.io_req_ready !== 4'b0) begin n_fail++; $display("FAIL exh_ack_cycle_ready: got %b expected 0000", bus.io_req_ready); end
      tick();
      drive(4'b1111, 1'b1, 1'b0, '0);
      n_checks++; if (bus.io_busy !== 4'b1011) begin n_fail++; $display("FAIL exh_release_busy: got %b expected 1011", bus.io_busy); end
      n_checks++; if (bus.io_req_ready !== 4'b0010) begin n_fail++; $display("FAIL exh_realloc_ready: got %b expected 0010", bus.io_req_ready); end
      tick();
      drive(4'b0000, 1'b1, 1'b0, '0);
      n_checks++;
      if (bus.io_grant_valid !== 1'b1 || bus.io_grant_req !== 2'd1 || bus.io_grant_sink !== 2'd2) begin
         n_fail++; $display("FAIL exh_grant: got v=%b req=%0d sink=%0d expected v=1 req=1 sink=2", bus.io_grant_valid, bus.io_grant_req, bus.io_grant_sink);
      end
      n_checks++; if (bus.io_busy !== 4'b1111) begin n_fail++; $display("FAIL exh_busy_after: got %b expected 1111", bus.io_busy); end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      drive(4'b0001, 1'b0, 1'b0, '0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(4'b0010, 1'b0, 1'b0, '0);
         n_checks++;
         if (bus.io_grant_valid !== 1'b1 || bus.io_grant_req !== 2'd0 || bus.io_grant_sink !== 2'd0) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got v=%b req=%0d sink=%0d expected v=1 req=0 sink=0", i, bus.io_grant_valid, bus.io_grant_req, bus.io_grant_sink);
         end
         n_checks++; if (bus.io_req_ready !== 4'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, bus.io_req_ready); end
         tick();
      end
      drive(4'b0010, 1'b1, 1'b0, '0);
      n_checks++; if (bus.io_req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_passthru_ready: got %b expected 0010", bus.io_req_ready); end
      tick();
      drive(4'b0000, 1'b1, 1'b0, '0);
      n_checks++;
      if (bus.io_grant_valid !== 1'b1 || bus.io_grant_req !== 2'd1 || bus.io_grant_sink !== 2'd1) begin
         n_fail++; $display("FAIL bp_no_bubble: got v=%b req=%0d sink=%0d expected v=1 req=1 sink=1", bus.io_grant_valid, bus.io_grant_req, bus.io_grant_sink);
      end
      tick();
      drive(4'b0000, 1'b1, 1'b0, '0);
      n_checks++; if (bus.io_grant_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", bus.io_grant_valid); end
      tick();
   endtask

   task automatic test_spurious_ack();
      do_reset();
      drive(4'b0001, 1'b1, 1'b0, '0);
      tick();
      drive(4'b0000, 1'b1, 1'b1, 2'd3);
      n_checks++; if (bus.io_err !== 1'b0) begin n_fail++; $display("FAIL spur_err_before: got %b expected 0", bus.io_err); end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(4'b0000, 1'b1, 1'b0, '0);
         n_checks++; if (bus.io_err !== 1'b1) begin n_fail++; $display("FAIL spur_err_sticky[%0d]: got %b expected 1", i, bus.io_err); end
         n_checks++; if (bus.io_busy !== 4'b0001) begin n_fail++; $display("FAIL spur_busy[%0d]: got %b expected 0001", i, bus.io_busy); end
         tick();
      end
      do_reset();
      drive(4'b0000, 1'b0, 1'b0, '0);
      n_checks++; if (bus.io_err !== 1'b0) begin n_fail++; $display("FAIL spur_err_cleared: got %b expected 0", bus.io_err); end
      tick();
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(4'b0001, 1'b1, 1'b0, '0);
         tick();
      end
      drive(4'b0000, 1'b0, 1'b1, 2'd0);
      tick();
      drive(4'b0000, 1'b0, 1'b0, '0);
      n_checks++; if (bus.io_busy !== 4'b0110) begin n_fail++; $display("FAIL mid_pre_busy: got %b expected 0110", bus.io_busy); end
      n_checks++; if (bus.io_grant_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", bus.io_grant_valid); end
      reset = 1'b1;
      tick();
      drive(4'b1111, 1'b1, 1'b0, '0);
      n_checks++; if (bus.io_grant_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid: got %b expected 0", bus.io_grant_valid); end
      n_checks++; if (bus.io_busy !== 4'b0) begin n_fail++; $display("FAIL mid_post_busy: got %b expected 0000", bus.io_busy); end
      n_checks++; if (bus.io_idle !== 1'b1) begin n_fail++; $display("FAIL mid_post_idle: got %b expected 1", bus.io_idle); end
      n_checks++; if (bus.io_req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_post_priority: got %b expected 0001", bus.io_req_ready); end
      tick();
      drive(4'b0000, 1'b1, 1'b0, '0);
      n_checks++;
      if (bus.io_grant_valid !== 1'b1 || bus.io_grant_req !== 2'd0 || bus.io_grant_sink !== 2'd0) begin
         n_fail++; $display("FAIL mid_first_grant: got v=%b req=%0d sink=%0d expected v=1 req=0 sink=0", bus.io_grant_valid, bus.io_grant_req, bus.io_grant_sink);
      end
      tick();
   endtask

   initial begin
      bus.io_req_valid   = 4'b0;
      bus.io_grant_ready = 1'b0;
      bus.io_ack_valid   = 1'b0;
      bus.io_ack_sink    = '0;
      m_busy = 4'b0; m_ptr = NR - 1; m_ov = 1'b0; m_err = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_exhaust();
      test_backpressure();
      test_spurious_ack();
      test_reset_mid_grant();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tl_sink_id_allocator.md
Name: tl_sink_id_allocator

Overview:
- Scheduler for the TileLink manager-side sink-ID resource.
- Arbitrates round-robin among NUM_REQ grant requesters and allocates a free sink ID for each grant it issues.
- Issues each grant through a registered output slot.
- Returns IDs to the free pool when the E-channel GrantAck queue (2-entry sink queue, always-drained deq side) presents the acknowledged sink.

Parameters:
NUM_REQ, 4, number of grant requesters (>=2, power of 2 not required)
SINK_BITS, 2, sink-ID width; NUM_SINKS = 2**SINK_BITS
REQ_BITS, derived, clog2(NUM_REQ)

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
io_req_valid  input  NUM_REQ  per-requester grant request
io_req_ready  output  NUM_REQ  one-hot (or zero) accept
io_grant_valid  output  1  registered grant available
io_grant_ready  input  1  downstream D-channel accepts grant
io_grant_req  output  REQ_BITS  index of the requester that won
io_grant_sink  output  SINK_BITS  allocated sink ID
io_ack_valid  input  1  GrantAck present (E-queue deq_valid, consumed every cycle)
io_ack_sink  input  SINK_BITS  sink ID being released
io_busy  output  NUM_SINKS  current allocation bitmap
io_idle  output  1  no IDs busy and no grant pending
io_err  output  1  sticky: ack for a non-busy sink

Behaviour:
- State:
  - busy[NUM_SINKS]
  - rr_ptr[REQ_BITS]: last winner
  - out_valid, out_req, out_sink: output slot
  - err: sticky error flag
- Reset values:
  - busy=0, rr_ptr=NUM_REQ-1, out_valid=0, out_req=0, out_sink=0, err=0.
  - All outputs therefore reset to: io_grant_valid=0, io_req_ready=0, io_busy=0, io_idle=1, io_err=0.
- slot_free = ~out_valid | io_grant_ready (pass-through fill in the same cycle as drain is permitted).
- any_free = ~&busy. free_id = lowest index with busy==0.
- Arbitration (combinational):
  - Search io_req_valid starting at rr_ptr+1 mod NUM_REQ, wrapping; the first asserted requester wins.
  - io_req_ready[win] = slot_free & any_free & |io_req_valid; all other ready bits are 0.
- Accept (fire = |(io_req_valid & io_req_ready)), effective next edge:
  - out_valid<=1, out_req<=win, out_sink<=free_id.
  - busy[free_id]<=1.
  - rr_ptr<=win.
- Drain without fire: if io_grant_ready & out_valid & ~fire, then out_valid<=0.
- Grant latency: request accepted at cycle N -> io_grant_valid at N+1. io_grant_* hold stable while io_grant_valid & ~io_grant_ready.
- Release:
  - If io_ack_valid & busy[io_ack_sink]: busy[io_ack_sink]<=0 at the next edge.
  - The freed ID is not visible to allocation until the following cycle; allocation uses only registered busy.
  - If io_ack_valid & ~busy[io_ack_sink]: err<=1, busy unchanged.
- Simultaneous alloc and release in one cycle: both update; they touch different bits, because allocation only takes a free ID.
- Full pool (busy all ones): every ready bit is 0. The requester pointer does not advance.
- No requests valid: rr_ptr holds.
- io_idle = ~|busy & ~out_valid.
- Reset asserted mid-operation: all state returns to reset values on that edge. An in-flight grant is dropped and all IDs are freed. Upstream must also be reset.

Decomposition:
- Shared package holds:
  - localparam NUM_SINKS.
  - typedef sink_id_t = logic [SINK_BITS-1:0].
  - Function lowest_zero_idx().
- One sub-module: rr_arbiter (NUM_REQ). Inputs: valid vector, rr_ptr. Outputs: win index, any-valid.
- Allocation bitmap, output slot and error flag live in the top level.

Test Plan:
1. Single requester: after reset, req_valid=4'b0001, grant_ready=1 for 4 cycles.
   - Grants carry req=0 with sinks 0,1,2,3 in cycles 1-4; busy=4'b1111.
   - Then req_ready=0.
2. Round-robin: req_valid=4'b1111, grant_ready=1, acks returned each next cycle.
   - Winners go 0,1,2,3,0. No requester is starved.
3. Pool exhaustion and release: all 4 IDs busy, then ack_valid=1, ack_sink=2.
   - busy=4'b1011 next cycle.
   - The following cycle the pending request is accepted with grant_sink=2.
4. Backpressure: grant_ready=0 with a grant pending.
   - grant_valid, req and sink stay stable; req_ready=0.
   - On grant_ready=1 with a new request in the same cycle, the new grant appears the next cycle with no bubble.
5. Spurious ack: ack_sink=3 while busy[3]=0.
   - io_err=1 and stays set; busy unchanged.
   - Reset clears err.
6. Reset mid-grant: reset asserted with out_valid=1 and busy=4'b0110.
   - Next cycle grant_valid=0, busy=0, io_idle=1.
   - req0 has priority again.
